sync_fifo_flags: RTL

SYNC_FIFO_FLAGS -- requirements
Module: sync_fifo_flags

---
 rtl/sync_fifo_flags.sv | 97 +++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// Synchronous FIFO with registered occupancy and status flags.
// Single clock, synchronous active-high reset, flush and error pulses.
module sync_fifo_flags #(
  parameter int DWIDTH    = 8,
  parameter int DEPTH     = 16,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DWIDTH-1:0] din,
  input  logic              wr,
  input  logic              rd,
  output logic [DWIDTH-1:0] dout,
  output logic [$clog2(DEPTH)-1:0] wrptr,
  output logic [$clog2(DEPTH)-1:0] rdptr,
  output logic [$clog2(DEPTH):0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  logic [DWIDTH-1:0] mem [DEPTH];

  ptr_t wp;
  ptr_t rp;
  ptr_t cnt_nxt;
  logic wr_ok;
  logic rd_ok;

  // A full FIFO still takes a write when a read frees a slot this cycle.
  assign rd_ok = rd & ~empty;
  assign wr_ok = wr & (~full | rd_ok);

  assign wrptr = wp[AW-1:0];
  assign rdptr = rp[AW-1:0];

  // Next occupancy, used for both the count and the flags.
  always_comb begin
    cnt_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_nxt = count + ptr_t'(1);
      2'b01:   cnt_nxt = count - ptr_t'(1);
      default: cnt_nxt = count;
    endcase
  end

  // Pointers, occupancy, status flags and error pulses.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wp           <= '0;
      rp           <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wp           <= wp + ptr_t'(wr_ok);
      rp           <= rp + ptr_t'(rd_ok);
      count        <= cnt_nxt;
      full         <= cnt_nxt == ptr_t'(DEPTH);
      empty        <= cnt_nxt == '0;
      almost_full  <= cnt_nxt >= ptr_t'(AFULL_TH);
      almost_empty <= cnt_nxt <= ptr_t'(AEMPTY_TH);
      overflow     <= wr & ~wr_ok;
      underflow    <= rd & ~rd_ok;
    end
  end

  // Storage array; deliberately has no reset.
  always_ff @(posedge clk) begin
    if (!rst && !flush && wr_ok) begin
      mem[wp[AW-1:0]] <= din;
    end
  end

  // Registered read data; holds unless a read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (!flush && rd_ok) begin
      dout <= mem[rp[AW-1:0]];
    end
  end

endmodule
